// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand capture, RAW forwarding, stalls, stall counter.
// Forwarding from EX/MEM and MEM/WB is built only when ID_EX_FWD_EN is defined.
module id_ex_operand_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic                 id_use_rs2,
  input  logic                 id_alusrc,
  input  logic [3:0]           id_alusel,
  input  logic                 id_ir5,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 id_memwrite,
  input  logic [RF_ADDR_W-1:0] exmem_rd,
  input  logic                 exmem_regwrite,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic [RF_ADDR_W-1:0] memwb_rd,
  input  logic                 memwb_regwrite,
  input  logic [XLEN-1:0]      memwb_result,
  input  logic                 flush_i,
  output logic [XLEN-1:0]      ALU_A,
  output logic [XLEN-1:0]      ALU_B,
  output logic [4:0]           shamt,
  output logic                 IR_5,
  output logic [3:0]           ALUsel,
  output logic                 ex_valid,
  output logic                 ex_regwrite,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_store_data,
  output logic                 stall_o,
  output logic [31:0]          stall_cnt
);

  logic                 valid_q, valid_d;
  logic                 regwrite_q, regwrite_d;
  logic                 memread_q, memread_d;
  logic                 memwrite_q, memwrite_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic                 alusrc_q, alusrc_d;
  logic [3:0]           alusel_q, alusel_d;
  logic                 ir5_q, ir5_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]      rs1_fwd, rs2_fwd;

`ifdef ID_EX_FWD_EN
  logic [RF_ADDR_W-1:0] rs1_q, rs1_d;
  logic [RF_ADDR_W-1:0] rs2_q, rs2_d;

  function automatic logic [XLEN-1:0] fwd(input logic [RF_ADDR_W-1:0] rs,
                                          input logic [XLEN-1:0]      rf);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
      return exmem_result;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
      return memwb_result;
    end
    return rf;
  endfunction

  assign rs1_fwd = fwd(rs1_q, rs1_data_q);
  assign rs2_fwd = fwd(rs2_q, rs2_data_q);

  // Only a load in EX cannot be forwarded in time.
  assign stall_o = valid_q && memread_q && (rd_q != '0) && id_valid &&
                   ((rd_q == id_rs1) || (id_use_rs2 && (rd_q == id_rs2)));
`else
  logic unused_fwd;
  logic hit_rs1, hit_rs2;

  assign unused_fwd = ^{exmem_result, memwb_rd, memwb_regwrite, memwb_result};
  assign rs1_fwd    = rs1_data_q;
  assign rs2_fwd    = rs2_data_q;

  // MEM/WB never stalls: the register file is write-first.
  assign hit_rs1 = (id_rs1 != '0) &&
                   ((valid_q && regwrite_q && (rd_q == id_rs1)) ||
                    (exmem_regwrite && (exmem_rd == id_rs1)));
  assign hit_rs2 = (id_rs2 != '0) &&
                   ((valid_q && regwrite_q && (rd_q == id_rs2)) ||
                    (exmem_regwrite && (exmem_rd == id_rs2)));
  assign stall_o = id_valid && (hit_rs1 || (id_use_rs2 && hit_rs2));
`endif

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    alusel_d   = alusel_q;
    ir5_d      = ir5_q;
`ifdef ID_EX_FWD_EN
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
`endif
    if (flush_i || stall_o) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else begin
      valid_d    = id_valid;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
      rd_d       = id_rd;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      alusel_d   = id_alusel;
      ir5_d      = id_ir5;
`ifdef ID_EX_FWD_EN
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
`endif
    end
  end

  // A flushed stall is not counted; the counter saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      rd_q        <= '0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alusrc_q    <= 1'b0;
      alusel_q    <= '0;
      ir5_q       <= 1'b0;
      stall_cnt_q <= '0;
`ifdef ID_EX_FWD_EN
      rs1_q       <= '0;
      rs2_q       <= '0;
`endif
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alusrc_q    <= alusrc_d;
      alusel_q    <= alusel_d;
      ir5_q       <= ir5_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef ID_EX_FWD_EN
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
`endif
    end
  end

  assign ALU_A         = rs1_fwd;
  assign ALU_B         = alusrc_q ? imm_q : rs2_fwd;
  assign shamt         = alusrc_q ? imm_q[4:0] : rs2_fwd[4:0];
  assign ex_store_data = rs2_fwd;
  assign IR_5          = ir5_q;
  assign ALUsel        = alusel_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign stall_cnt     = stall_cnt_q;

endmodule
